rom_arbiter_n: RTL and testbench
================================

# rom_arbiter_n

Parametrised N-channel arbiter between ROM cache segments and the 32-bit SDRAM controller; next generation of the five-fixed-channel ROM controller. It adds selectable fixed-priority or round-robin arbitration and an in-order tag queue for multiple outstanding SDRAM reads. It also provides a byte-to-word IOCTL download path with flush of partial final words. It sits between the per-ROM segment caches and the SDRAM controller.

## Interface
- NUM_CH, 5, number of read channels; channel 0 has highest fixed priority
- ADDR_W, 23, SDRAM word address width
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- MAX_PENDING, 2, tag queue depth (power of two, 1..8)
- DL_INDEX, 0, ioctl_index value that enables SDRAM writes
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- ch_req  in  NUM_CH  per-channel read request, level, held until ch_ack
- ch_addr  in  NUM_CH*ADDR_W  per-channel word address, channel i at [i*ADDR_W +: ADDR_W]
- ch_ack  out  NUM_CH  request accepted (one-hot, one cycle)
- ch_valid  out  NUM_CH  read data valid for that channel (one-hot, one cycle)
- ch_q  out  32  read data, broadcast copy of sdram_q
- ioctl_addr  in  25  download byte address
- ioctl_data  in  8  download byte
- ioctl_index  in  16  download target index
- ioctl_wr  in  1  byte strobe
- ioctl_download  in  1  download active
- sdram_addr  out  ADDR_W  word address
- sdram_data  out  32  write data
- sdram_we  out  1  write enable
- sdram_req  out  1  request
- sdram_ack  in  1  request accepted
- sdram_valid  in  1  read data valid, in request order
- sdram_q  in  32  read data
- busy  out  1  tag queue non-empty or download word pending
- err  out  1  sticky: orphan sdram_valid or download byte overrun

## Operation
- Read path, active only when ioctl_download = 0 and no download word pending:
  - Grant = arbitration over ch_req.
  - sdram_req = any ch_req & !queue_full.
  - sdram_addr = granted ch_addr.
  - sdram_we = 0.
- Fixed mode: lowest asserted index wins.
- Round-robin mode: search starts at rr_ptr and wraps modulo NUM_CH. On sdram_ack, rr_ptr <= grant+1 (wraps to 0 after NUM_CH-1). rr_ptr resets to 0.
- Acknowledge: on sdram_ack with a read outstanding, ch_ack[grant] = 1 combinationally and the grant index is pushed into the tag queue.
- Valid: on sdram_valid with the queue non-empty, ch_valid[head] = 1 combinationally and the head is popped.
- Push and pop in the same cycle leave the count unchanged. A full queue with a simultaneous pop still blocks the request that cycle; no request is issued while full.
- sdram_valid with an empty queue: no ch_valid pulse, err set.
- Download path:
  - Each ioctl_wr while ioctl_download=1 writes byte k=ioctl_addr[1:0] into buf[8k+7:8k]; the word address is ioctl_addr[24:2].
  - The byte with ioctl_addr[1:0]=3 sets dl_pending.
  - While dl_pending: sdram_req=1, sdram_addr=word address, sdram_data=buf, sdram_we=(ioctl_index==DL_INDEX).
  - sdram_ack clears dl_pending and zeroes buf.
- Falling edge of ioctl_download with bytes written since the last word issue sets dl_pending; unwritten bytes are 0. The read path stays blocked until that flush is acked.
- ioctl_wr while dl_pending and not acked in the same cycle: byte dropped, err set.
- Downloads do not flush the tag queue; outstanding reads still retire to their channels.

## Timing
- Reset values:
  - Tag queue empty, rr_ptr=0, dl_pending=0, buf=0, err=0.
  - All outputs 0, except ch_q, which follows sdram_q.
- Latency:
  - Request to SDRAM is zero cycles: combinational from ch_req.
  - ch_ack and ch_valid are zero cycles from sdram_ack and sdram_valid.
- Download word issue: sdram_req rises the cycle after the 4th byte's ioctl_wr.
- Arbitration may change only when no ack is in flight. ch_req must be held stable until ch_ack.
- Reset mid-operation: queue cleared, in-flight SDRAM data afterwards treated as orphan (err set).

## Test plan
- Fixed mode, ch_req=5'b10110, immediate sdram_ack each cycle -> acks in order ch1, ch2, ch4; sdram_addr matches each channel's address.
- Round-robin mode, all five ch_req held, 10 acks -> grant sequence 0,1,2,3,4,0,1,2,3,4.
- MAX_PENDING=2: two acks, no valid -> sdram_req=0. Then one sdram_valid -> ch_valid for the first channel, sdram_req returns next cycle.
- Download of bytes 11,22,33,44 at addresses 0..3, ioctl_index=0 -> sdram_addr=0, sdram_data=32'h44332211, sdram_we=1. ioctl_index=1 -> sdram_we=0.
- Download of 6 bytes then ioctl_download falls -> second word address 1, data 32'h0000_6655, read path blocked until its ack.
- sdram_valid with empty queue -> no ch_valid, err=1 until reset.

Source files
------------

// File: rtl/rom_arbiter_n.sv
// rom_arbiter_n: N-channel read arbiter between ROM segment caches and a
// 32-bit SDRAM controller, with an in-order tag queue for outstanding reads
// and a byte-to-word IOCTL download path.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ch_req/ch_addr        per-channel read request (level) and word address
//   ch_ack/ch_valid/ch_q  one-hot accept, one-hot data valid, broadcast data
//   ioctl_*               download byte stream (addr, data, index, wr, download)
//   sdram_*               SDRAM controller request/ack/valid/data
//   busy                  tag queue non-empty or download word pending
//   err                   sticky: orphan sdram_valid or dropped download byte
module rom_arbiter_n #(
  parameter int NUM_CH      = 5,
  parameter int ADDR_W      = 23,
  parameter int ARB_MODE    = 0,
  parameter int MAX_PENDING = 2,
  parameter int DL_INDEX    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [31:0]              ch_q,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_data,
  input  logic [15:0]              ioctl_index,
  input  logic                     ioctl_wr,
  input  logic                     ioctl_download,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic [31:0]              sdram_data,
  output logic                     sdram_we,
  output logic                     sdram_req,
  input  logic                     sdram_ack,
  input  logic                     sdram_valid,
  input  logic [31:0]              sdram_q,
  output logic                     busy,
  output logic                     err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [ADDR_W-1:0] chan_addr [NUM_CH];
  logic [IDX_W-1:0]  tag_mem   [MAX_PENDING];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  rr_ptr, grant, idx;
  logic              found;
  logic              q_full, q_empty, read_active, read_req, push, pop;

  logic [31:0]       dl_buf, dl_buf_nx;
  logic [ADDR_W-1:0] dl_waddr, dl_waddr_nx;
  logic              dl_pending, dl_pending_nx;
  logic              dl_dirty, dl_dirty_nx;
  logic              dl_prev;
  logic              byte_wr, byte_ok, byte_drop, dl_fall;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_addr
    assign chan_addr[g] = ch_addr[g*ADDR_W +: ADDR_W];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration: fixed priority from index 0, or round-robin from rr_ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!found && ch_req[IDX_W'(i)]) begin
          grant = IDX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned off = 0; off < NUM_CH; off++) begin
        idx = IDX_W'((32'(rr_ptr) + off) % 32'(NUM_CH));
        if (!found && ch_req[idx]) begin
          grant = idx;
          found = 1'b1;
        end
      end
    end
  end

  // A partial download word (dl_dirty) also blocks reads, so the cycle in
  // which ioctl_download falls cannot slip a read ahead of the flush.
  assign read_active = !ioctl_download && !dl_pending && !dl_dirty;
  assign q_empty     = (count == '0);
  assign q_full      = (count == CNT_W'(MAX_PENDING));
  assign read_req    = read_active && (|ch_req) && !q_full;
  assign push        = read_req && sdram_ack;
  assign pop         = sdram_valid && !q_empty;

  assign ch_ack   = push ? (NUM_CH'(1) << grant) : '0;
  assign ch_valid = pop ? (NUM_CH'(1) << tag_mem[rd_ptr]) : '0;
  assign ch_q     = sdram_q;
  assign busy     = !q_empty || dl_pending;

  always_comb begin
    sdram_req  = 1'b0;
    sdram_addr = '0;
    sdram_data = '0;
    sdram_we   = 1'b0;
    if (dl_pending) begin
      sdram_req  = 1'b1;
      sdram_addr = dl_waddr;
      sdram_data = dl_buf;
      sdram_we   = (ioctl_index == 16'(DL_INDEX));
    end else if (read_active && (|ch_req)) begin
      sdram_req  = read_req;
      sdram_addr = chan_addr[grant];
    end
  end

  // Download byte assembly; an ack in the same cycle frees the buffer for
  // the incoming byte instead of dropping it.
  assign byte_wr   = ioctl_wr && ioctl_download;
  assign byte_ok   = byte_wr && (!dl_pending || sdram_ack);
  assign byte_drop = byte_wr && dl_pending && !sdram_ack;
  assign dl_fall   = dl_prev && !ioctl_download;

  always_comb begin
    dl_buf_nx     = (dl_pending && sdram_ack) ? '0 : dl_buf;
    dl_pending_nx = dl_pending && !sdram_ack;
    dl_dirty_nx   = dl_dirty;
    dl_waddr_nx   = dl_waddr;
    if (byte_ok) begin
      case (ioctl_addr[1:0])
        2'd0:    dl_buf_nx[7:0]   = ioctl_data;
        2'd1:    dl_buf_nx[15:8]  = ioctl_data;
        2'd2:    dl_buf_nx[23:16] = ioctl_data;
        default: dl_buf_nx[31:24] = ioctl_data;
      endcase
      dl_waddr_nx = ADDR_W'(ioctl_addr[24:2]);
      if (ioctl_addr[1:0] == 2'd3) begin
        dl_pending_nx = 1'b1;
        dl_dirty_nx   = 1'b0;
      end else begin
        dl_dirty_nx   = 1'b1;
      end
    end else if (dl_fall && dl_dirty) begin
      dl_pending_nx = 1'b1;
      dl_dirty_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_PENDING; i++) tag_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      dl_buf     <= '0;
      dl_waddr   <= '0;
      dl_pending <= 1'b0;
      dl_dirty   <= 1'b0;
      dl_prev    <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= ptr_inc(wr_ptr);
        rr_ptr          <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      dl_buf     <= dl_buf_nx;
      dl_waddr   <= dl_waddr_nx;
      dl_pending <= dl_pending_nx;
      dl_dirty   <= dl_dirty_nx;
      dl_prev    <= ioctl_download;
      if (byte_drop || (sdram_valid && q_empty)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_arbiter_n.sv
// Bench for rom_arbiter_n: instance 0 in fixed-priority mode, instance 1 in
// round-robin mode; ioctl and sdram_q are shared, channel/SDRAM handshakes
// are per instance.
module tb_rom_arbiter_n;
  localparam int NCH  = 5;
  localparam int AW   = 23;
  localparam int MAXP = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NCH-1:0]    ch_req      [2];
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_ack      [2];
  logic [NCH-1:0]    ch_valid    [2];
  logic [31:0]       ch_q        [2];
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_data;
  logic [15:0]       ioctl_index;
  logic              ioctl_wr, ioctl_download;
  logic [AW-1:0]     sdram_addr  [2];
  logic [31:0]       sdram_data  [2];
  logic              sdram_we    [2];
  logic              sdram_req   [2];
  logic              sdram_ack   [2];
  logic              sdram_valid [2];
  logic [31:0]       sdram_q;
  logic              busy        [2];
  logic              err         [2];

  rom_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .ARB_MODE(0), .MAX_PENDING(MAXP), .DL_INDEX(0)) u_fix (
    .clk(clk), .reset(reset), .ch_req(ch_req[0]), .ch_addr(ch_addr), .ch_ack(ch_ack[0]),
    .ch_valid(ch_valid[0]), .ch_q(ch_q[0]), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
    .sdram_addr(sdram_addr[0]), .sdram_data(sdram_data[0]), .sdram_we(sdram_we[0]),
    .sdram_req(sdram_req[0]), .sdram_ack(sdram_ack[0]), .sdram_valid(sdram_valid[0]),
    .sdram_q(sdram_q), .busy(busy[0]), .err(err[0]));

  rom_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .ARB_MODE(1), .MAX_PENDING(MAXP), .DL_INDEX(0)) u_rr (
    .clk(clk), .reset(reset), .ch_req(ch_req[1]), .ch_addr(ch_addr), .ch_ack(ch_ack[1]),
    .ch_valid(ch_valid[1]), .ch_q(ch_q[1]), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
    .sdram_addr(sdram_addr[1]), .sdram_data(sdram_data[1]), .sdram_we(sdram_we[1]),
    .sdram_req(sdram_req[1]), .sdram_ack(sdram_ack[1]), .sdram_valid(sdram_valid[1]),
    .sdram_q(sdram_q), .busy(busy[1]), .err(err[1]));

  int errors = 0;
  int checks = 0;

  // Reference model state: tag queues per instance, round-robin pointer.
  int mq0[$];
  int mq1[$];
  int mrr;

  typedef struct {
    int         d;
    logic [4:0] req;
    logic       ack;
    logic       valid;
    logic [4:0] e_ack;
    logic [4:0] e_valid;
    logic       e_req;
    int         e_ch;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h0A_0000 + 32'(i) * 32'h1357);
  endfunction

  function automatic int fixed_grant(input logic [4:0] m);
    for (int i = 0; i < NCH; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int rr_grant(input logic [4:0] m, input int p);
    for (int off = 0; off < NCH; off++) if (m[(p + off) % NCH]) return (p + off) % NCH;
    return -1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic int qhead(input int d);
    return (d == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      ch_req[d]      = '0;
      sdram_ack[d]   = 1'b0;
      sdram_valid[d] = 1'b0;
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    ioctl_download = 1'b0;
    ioctl_index    = '0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    reset          = 1'b1;
    sdram_q        = $urandom;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst ch_ack", ch_ack[d], 0);
      check("rst ch_valid", ch_valid[d], 0);
      check("rst sdram_req", sdram_req[d], 0);
      check("rst sdram_addr", sdram_addr[d], 0);
      check("rst sdram_data", sdram_data[d], 0);
      check("rst sdram_we", sdram_we[d], 0);
      check("rst busy", busy[d], 0);
      check("rst err", err[d], 0);
      check("rst ch_q", ch_q[d], sdram_q);
    end
    tick();
    reset = 1'b0;
    mq0.delete();
    mq1.delete();
    mrr = 0;
  endtask

  task automatic dl_word_check(input string tag, input logic [AW-1:0] a, input logic [31:0] dat,
                               input logic we);
    for (int d = 0; d < 2; d++) begin
      check({tag, " req"}, sdram_req[d], 1);
      check({tag, " addr"}, sdram_addr[d], a);
      check({tag, " data"}, sdram_data[d], dat);
      check({tag, " we"}, sdram_we[d], we);
      check({tag, " busy"}, busy[d], 1);
    end
  endtask

  task automatic dl_bytes(input int first, input int n, input int base);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b          = 8'(8'h11 * (first + i + 1));
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(base + first + i);
      ioctl_data = b;
      #1;
      check("dl fill req", sdram_req[0], 0);
      tick();
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic ack_both(input logic v);
    sdram_ack[0] = v;
    sdram_ack[1] = v;
  endtask

  initial begin
    logic [4:0] rmask [2];
    int         g, qs;
    logic       ereq, pop;
    logic [4:0] eack, evalid;

    for (int i = 0; i < NCH; i++) ch_addr[i*AW +: AW] = addr_of(i);
    idle();
    ioctl_download = 1'b0;
    ioctl_index    = '0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    sdram_q        = '0;
    reset          = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    do_reset();

    // ---------------- table-driven vectors ----------------
    tbl.push_back('{0, 5'b10110, 1'b1, 1'b0, 5'b00010, 5'b00000, 1'b1, 1});
    tbl.push_back('{0, 5'b10100, 1'b1, 1'b1, 5'b00100, 5'b00010, 1'b1, 2});
    tbl.push_back('{0, 5'b10000, 1'b1, 1'b1, 5'b10000, 5'b00100, 1'b1, 4});
    tbl.push_back('{0, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b10000, 1'b0, -1});
    tbl.push_back('{0, 5'b00011, 1'b1, 1'b0, 5'b00001, 5'b00000, 1'b1, 0});
    tbl.push_back('{0, 5'b00010, 1'b1, 1'b0, 5'b00010, 5'b00000, 1'b1, 1});
    tbl.push_back('{0, 5'b00100, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0, -1});
    tbl.push_back('{0, 5'b00100, 1'b0, 1'b1, 5'b00000, 5'b00001, 1'b0, -1});
    tbl.push_back('{0, 5'b00100, 1'b1, 1'b1, 5'b00100, 5'b00010, 1'b1, 2});
    tbl.push_back('{0, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b00100, 1'b0, -1});
    for (int k = 0; k < 10; k++)
      tbl.push_back('{1, 5'b11111, 1'b1, (k > 0), 5'(1 << (k % 5)),
                      (k > 0) ? 5'(1 << ((k - 1) % 5)) : 5'b0, 1'b1, k % 5});
    tbl.push_back('{1, 5'b00000, 1'b0, 1'b1, 5'b00000, 5'b10000, 1'b0, -1});
    tbl.push_back('{1, 5'b10010, 1'b1, 1'b0, 5'b00010, 5'b00000, 1'b1, 1});
    tbl.push_back('{1, 5'b10011, 1'b1, 1'b1, 5'b10000, 5'b00010, 1'b1, 4});
    tbl.push_back('{1, 5'b00011, 1'b0, 1'b1, 5'b00000, 5'b10000, 1'b1, 0});

    for (int k = 0; k < tbl.size(); k++) begin
      idle();
      ch_req[tbl[k].d]      = tbl[k].req;
      sdram_ack[tbl[k].d]   = tbl[k].ack;
      sdram_valid[tbl[k].d] = tbl[k].valid;
      sdram_q               = $urandom;
      #1;
      check($sformatf("tbl%0d ch_ack", k), ch_ack[tbl[k].d], tbl[k].e_ack);
      check($sformatf("tbl%0d ch_valid", k), ch_valid[tbl[k].d], tbl[k].e_valid);
      check($sformatf("tbl%0d sdram_req", k), sdram_req[tbl[k].d], tbl[k].e_req);
      if (tbl[k].e_ch >= 0)
        check($sformatf("tbl%0d sdram_addr", k), sdram_addr[tbl[k].d], addr_of(tbl[k].e_ch));
      check($sformatf("tbl%0d err", k), err[tbl[k].d], 0);
      tick();
    end
    idle();

    // ---------------- randomized reads vs. model ----------------
    do_reset();
    rmask[0] = '0;
    rmask[1] = '0;
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++)
          if (!rmask[d][c] && $urandom_range(0, 2) == 0) rmask[d][c] = 1'b1;
        ch_req[d]      = rmask[d];
        sdram_ack[d]   = ($urandom_range(0, 3) != 0);
        sdram_valid[d] = (qsize(d) > 0) && ($urandom_range(0, 1) == 1);
      end
      sdram_q = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        qs     = qsize(d);
        ereq   = (rmask[d] != 0) && (qs < MAXP);
        g      = (d == 0) ? fixed_grant(rmask[d]) : rr_grant(rmask[d], mrr);
        eack   = (ereq && sdram_ack[d]) ? 5'(1 << g) : 5'b0;
        pop    = sdram_valid[d] && (qs > 0);
        evalid = pop ? 5'(1 << qhead(d)) : 5'b0;
        check("rnd sdram_req", sdram_req[d], ereq);
        check("rnd ch_ack", ch_ack[d], eack);
        check("rnd ch_valid", ch_valid[d], evalid);
        if (ereq) check("rnd sdram_addr", sdram_addr[d], addr_of(g));
        check("rnd sdram_we", sdram_we[d], 0);
        check("rnd busy", busy[d], qs > 0);
        check("rnd err", err[d], 0);
        check("rnd ch_q", ch_q[d], sdram_q);
        if (pop) begin
          if (d == 0) void'(mq0.pop_front());
          else        void'(mq1.pop_front());
        end
        if (eack != 0) begin
          if (d == 0) mq0.push_back(g);
          else begin
            mq1.push_back(g);
            mrr = (g + 1) % NCH;
          end
          rmask[d][g] = 1'b0;
        end
      end
      tick();
    end
    idle();

    // ---------------- download path ----------------
    do_reset();
    ioctl_download = 1'b1;
    ioctl_index    = 16'd0;
    dl_bytes(0, 4, 0);
    #1; dl_word_check("dlA", 0, 32'h4433_2211, 1'b1);
    tick();
    #1; check("dlA hold req", sdram_req[0], 1);
    ack_both(1'b1);
    tick();
    ack_both(1'b0);
    #1;
    check("dlA done req", sdram_req[0], 0);
    check("dlA done busy", busy[0], 0);

    ioctl_index = 16'd1;
    dl_bytes(0, 4, 0);
    #1; dl_word_check("dlB", 0, 32'h4433_2211, 1'b0);
    ack_both(1'b1);
    tick();
    ack_both(1'b0);

    ioctl_index = 16'd0;
    dl_bytes(0, 4, 0);
    #1; dl_word_check("dlC0", 0, 32'h4433_2211, 1'b1);
    ack_both(1'b1);
    tick();
    ack_both(1'b0);
    dl_bytes(4, 2, 0);
    ioctl_download = 1'b0;
    tick();
    ch_req[0] = 5'b00001;
    #1;
    dl_word_check("dlC1", 1, 32'h0000_6655, 1'b1);
    check("dlC1 blocked ack", ch_ack[0], 0);
    tick();
    ack_both(1'b1);
    #1;
    check("dlC1 flush ack no ch_ack", ch_ack[0], 0);
    check("dlC1 flush ack addr", sdram_addr[0], 1);
    tick();
    ack_both(1'b0);
    #1;
    check("dlC read req", sdram_req[0], 1);
    check("dlC read addr", sdram_addr[0], addr_of(0));
    check("dlC read we", sdram_we[0], 0);
    tick();
    sdram_ack[0] = 1'b1;
    #1; check("dlC read ack", ch_ack[0], 5'b00001);
    tick();
    idle();
    sdram_valid[0] = 1'b1;
    #1; check("dlC read valid", ch_valid[0], 5'b00001);
    tick();
    idle();

    // Overrun: byte written while a word is pending and not acked.
    ioctl_download = 1'b1;
    dl_bytes(0, 4, 8);
    #1; dl_word_check("ovr", 2, 32'h4433_2211, 1'b1);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd12;
    ioctl_data = 8'hEE;
    #1; check("ovr err before", err[0], 0);
    tick();
    ioctl_wr = 1'b0;
    #1;
    check("ovr err set", err[0], 1);
    check("ovr data kept", sdram_data[0], 32'h4433_2211);
    ack_both(1'b1);
    tick();
    ack_both(1'b0);
    ioctl_download = 1'b0;
    tick();
    tick();
    #1;
    check("ovr no flush req", sdram_req[0], 0);
    check("ovr err sticky", err[0], 1);
    do_reset();

    // Orphan sdram_valid.
    sdram_valid[0] = 1'b1;
    #1; check("orphan ch_valid", ch_valid[0], 0);
    tick();
    sdram_valid[0] = 1'b0;
    #1; check("orphan err", err[0], 1);
    tick();
    tick();
    #1; check("orphan err sticky", err[0], 1);
    do_reset();

    // Reset with a read outstanding; its data afterwards is an orphan.
    ch_req[0]    = 5'b00100;
    sdram_ack[0] = 1'b1;
    #1; check("mid ack", ch_ack[0], 5'b00100);
    tick();
    idle();
    #1; check("mid busy", busy[0], 1);
    reset = 1'b1;
    #1; check("mid rst busy", busy[0], 0);
    tick();
    reset = 1'b0;
    sdram_valid[0] = 1'b1;
    #1; check("mid orphan ch_valid", ch_valid[0], 0);
    tick();
    sdram_valid[0] = 1'b0;
    #1; check("mid orphan err", err[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
